// File: rtl/ras_repair.sv
// ras_repair: return address stack, speculatively updated at fetch and repaired from an Execute checkpoint.
// Optional `RAS_TOP_REPAIR_EN: the checkpoint also carries the top entry, which repair writes back.
module ras_repair #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     StallE,
  input  logic                     FlushD,
  input  logic                     FlushE,
  input  logic                     BPCallF,
  input  logic                     BPReturnF,
  input  logic [XLEN-1:0]          PCLinkF,
  input  logic                     CallE,
  input  logic                     ReturnE,
  input  logic [XLEN-1:0]          PCLinkE,
  input  logic                     BPWrongE,
  output logic [XLEN-1:0]          RASPCF,
  output logic [$clog2(DEPTH):0]   RASCountF,
  output logic                     RASOverflowF
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   tos;
  logic [CW-1:0]   count;

  logic [PW-1:0]   ckptTos_p1, ckptTos_p2;
  logic [CW-1:0]   ckptCount_p1, ckptCount_p2;
  logic            vld_p1, vld_p2;
`ifdef RAS_TOP_REPAIR_EN
  logic [XLEN-1:0] ckptTop_p1, ckptTop_p2;
`endif

  logic            repairEn, opCall, opRet, wrEn, ovfNext;
  logic [PW-1:0]   baseTos, tosNext, wrAddr;
  logic [CW-1:0]   baseCount, countNext;
  logic [XLEN-1:0] link;

  assign RASPCF    = mem[tos];
  assign RASCountF = count;

  // A valid repair replaces the fetch operation and starts from the checkpointed pointer/count
  always_comb begin
    repairEn  = BPWrongE & vld_p2;
    baseTos   = tos;
    baseCount = count;
    opCall    = 1'b0;
    opRet     = 1'b0;
    link      = PCLinkF;
    if (repairEn) begin
      baseTos   = ckptTos_p2;
      baseCount = ckptCount_p2;
      opCall    = CallE;
      opRet     = ReturnE;
      link      = PCLinkE;
    end else if (!StallF && !BPWrongE) begin
      opCall = BPCallF;
      opRet  = BPReturnF;
    end

    tosNext   = baseTos;
    countNext = baseCount;
    wrEn      = 1'b0;
    wrAddr    = baseTos;
    ovfNext   = 1'b0;
    if (opCall && opRet) begin
      wrEn = 1'b1;
      if (baseCount == '0) countNext = CW'(1);
    end else if (opCall) begin
      tosNext = baseTos + PW'(1);
      wrAddr  = baseTos + PW'(1);
      wrEn    = 1'b1;
      if (baseCount == FULL) ovfNext = 1'b1;
      else countNext = baseCount + CW'(1);
    end else if (opRet && baseCount != '0) begin
      tosNext   = baseTos - PW'(1);
      countNext = baseCount - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos          <= '0;
      count        <= '0;
      RASOverflowF <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tos          <= tosNext;
      count        <= countNext;
      RASOverflowF <= ovfNext;
`ifdef RAS_TOP_REPAIR_EN
      if (repairEn) mem[ckptTos_p2] <= ckptTop_p2;
`endif
      // A coroutine swap on repair targets the same entry; its link must win
      if (wrEn) mem[wrAddr] <= link;
    end
  end

  // Stage F->D (_p1) and D->E (_p2) checkpoints
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckptTos_p1   <= '0;
      ckptCount_p1 <= '0;
      vld_p1       <= 1'b0;
      ckptTos_p2   <= '0;
      ckptCount_p2 <= '0;
      vld_p2       <= 1'b0;
    end else begin
      if (FlushD) vld_p1 <= 1'b0;
      else if (!StallD) begin
        vld_p1       <= 1'b1;
        ckptTos_p1   <= tos;
        ckptCount_p1 <= count;
      end
      if (FlushE) vld_p2 <= 1'b0;
      else if (!StallE) begin
        vld_p2       <= vld_p1;
        ckptTos_p2   <= ckptTos_p1;
        ckptCount_p2 <= ckptCount_p1;
      end
    end
  end

`ifdef RAS_TOP_REPAIR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckptTop_p1 <= '0;
      ckptTop_p2 <= '0;
    end else begin
      if (!FlushD && !StallD) ckptTop_p1 <= mem[tos];
      if (!FlushE && !StallE) ckptTop_p2 <= ckptTop_p1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_repair.sv
// Directed bench for ras_repair: stack-level reference model checked every cycle plus literal expectations.
module tb_ras_repair;
  localparam int D = 16;

  logic        clk, reset;
  logic        StallF, StallD, StallE, FlushD, FlushE;
  logic        BPCallF, BPReturnF, CallE, ReturnE, BPWrongE;
  logic [63:0] PCLinkF, PCLinkE;
  logic [63:0] RASPCF;
  logic [4:0]  RASCountF;
  logic        RASOverflowF;

  int nChecks = 0;
  int nErrors = 0;

  ras_repair #(.XLEN(64), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .BPCallF(BPCallF), .BPReturnF(BPReturnF), .PCLinkF(PCLinkF),
    .CallE(CallE), .ReturnE(ReturnE), .PCLinkE(PCLinkE),
    .BPWrongE(BPWrongE),
    .RASPCF(RASPCF), .RASCountF(RASCountF), .RASOverflowF(RASOverflowF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: circular array, pointer and count, plus two checkpoint slots
  logic [63:0] mMem [D];
  int          mTos = 0, mCount = 0;
  bit          mOvf = 0, ovfNext = 0;
  int          dTos = 0, dCount = 0, eTos = 0, eCount = 0;
  logic [63:0] dTop = 0, eTop = 0;
  bit          dV = 0, eV = 0;
  int          cTos, cCount;
  logic [63:0] cTop;
  int          nViol = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyOp(input bit c, input bit r, input logic [63:0] l);
    if (c && r) begin
      mMem[mTos] = l;
      if (mCount == 0) mCount = 1;
    end else if (c) begin
      mTos = (mTos + 1) % D;
      mMem[mTos] = l;
      if (mCount == D) ovfNext = 1;
      else mCount++;
    end else if (r && mCount > 0) begin
      mTos = (mTos + D - 1) % D;
      mCount--;
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mMem[i] = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < D; i++) mMem[i] = 0;
        mTos = 0; mCount = 0; mOvf = 0;
        dV = 0; eV = 0; dTos = 0; dCount = 0; dTop = 0; eTos = 0; eCount = 0; eTop = 0;
      end else begin
        cTos = mTos; cCount = mCount; cTop = mMem[mTos];
        ovfNext = 0;
        if (BPWrongE) begin
          if (eV) begin
            mTos = eTos;
            mCount = eCount;
`ifdef RAS_TOP_REPAIR_EN
            mMem[eTos] = eTop;
`endif
            applyOp(CallE, ReturnE, PCLinkE);
          end else begin
            nViol++;
            $display("NOTE protocol violation: BPWrongE with no valid E checkpoint at %0t", $time);
          end
        end else if (!StallF) begin
          applyOp(BPCallF, BPReturnF, PCLinkF);
        end
        mOvf = ovfNext;
        if (FlushE) eV = 0;
        else if (!StallE) begin eV = dV; eTos = dTos; eCount = dCount; eTop = dTop; end
        if (FlushD) dV = 0;
        else if (!StallD) begin dV = 1; dTos = cTos; dCount = cCount; dTop = cTop; end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("cyc RASPCF", RASPCF, mMem[mTos]);
        chk("cyc RASCountF", 64'(RASCountF), 64'(mCount));
        chk("cyc RASOverflowF", 64'(RASOverflowF), 64'(mOvf));
      end
    end
  end

  task automatic fcyc(input bit c, input bit r, input logic [63:0] l);
    BPCallF = c; BPReturnF = r; PCLinkF = l;
    @(negedge clk);
    BPCallF = 0; BPReturnF = 0;
  endtask

  task automatic doReset();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    reset = 0;
    {StallF, StallD, StallE, FlushD, FlushE} = '0;
    {BPCallF, BPReturnF, CallE, ReturnE, BPWrongE} = '0;
    PCLinkF = 0; PCLinkE = 0;
    repeat (2) @(negedge clk);
    chk("reset RASPCF", RASPCF, 64'h0);
    chk("reset count", 64'(RASCountF), 64'd0);
    chk("reset ovf", 64'(RASOverflowF), 64'd0);
    reset = 1;
    @(negedge clk);

    // Basic push/pop
    fcyc(1, 0, 64'h100); fcyc(1, 0, 64'h200); fcyc(1, 0, 64'h300);
    chk("push3 top", RASPCF, 64'h300);
    chk("push3 count", 64'(RASCountF), 64'd3);
    fcyc(0, 1, 0); chk("pop1 top", RASPCF, 64'h200);
    fcyc(0, 1, 0); chk("pop2 top", RASPCF, 64'h100);
    fcyc(0, 1, 0); chk("pop3 count", 64'(RASCountF), 64'd0);

    // Overflow: 17 pushes, oldest lost
    for (int i = 0; i < 17; i++) fcyc(1, 0, 64'h1000 + 64'(4 * i));
    chk("ovf pulse", 64'(RASOverflowF), 64'd1);
    chk("ovf count", 64'(RASCountF), 64'd16);
    for (int k = 0; k < 16; k++) begin
      chk("ovf pop top", RASPCF, 64'h1040 - 64'(4 * k));
      fcyc(0, 1, 0);
      if (k == 0) chk("ovf pulse end", 64'(RASOverflowF), 64'd0);
    end
    chk("drain count", 64'(RASCountF), 64'd0);

    // Underflow and coroutine swap at count=0
    fcyc(0, 1, 0);
    chk("underflow count", 64'(RASCountF), 64'd0);
    chk("underflow stale", RASPCF, 64'h1040);
    chk("underflow noX", 64'($isunknown(RASPCF)), 64'd0);
    fcyc(1, 1, 64'h500);
    chk("swap top", RASPCF, 64'h500);
    chk("swap count", 64'(RASCountF), 64'd1);

    // Wrong-path corruption and repair
    doReset();
    fcyc(1, 0, 64'h90); fcyc(1, 0, 64'hA0);
    fcyc(0, 0, 0);
    fcyc(1, 0, 64'hB0);
    StallE = 1;
    fcyc(0, 1, 0); fcyc(0, 1, 0);
    fcyc(1, 0, 64'hC0);
    chk("wrongpath top", RASPCF, 64'hC0);
    BPWrongE = 1; CallE = 0; ReturnE = 0; FlushD = 1; FlushE = 1;
    @(negedge clk);
    BPWrongE = 0; FlushD = 0; FlushE = 0; StallE = 0;
`ifdef RAS_TOP_REPAIR_EN
    chk("repair top", RASPCF, 64'hA0);
`else
    chk("repair top", RASPCF, 64'hC0);
`endif
    chk("repair count", 64'(RASCountF), 64'd2);

    // Repair with an Execute call while fetch also pushes
    fcyc(0, 0, 0); fcyc(0, 0, 0);
    BPWrongE = 1; CallE = 1; PCLinkE = 64'h7F0; FlushD = 1; FlushE = 1;
    fcyc(1, 0, 64'hDEAD);
    BPWrongE = 0; CallE = 0; FlushD = 0; FlushE = 0;
    chk("repcall top", RASPCF, 64'h7F0);
    chk("repcall count", 64'(RASCountF), 64'd3);
    fcyc(0, 1, 0);
`ifdef RAS_TOP_REPAIR_EN
    chk("repcall below", RASPCF, 64'hA0);
`else
    chk("repcall below", RASPCF, 64'hC0);
`endif

    // Stalled then flushed E checkpoint: repair must be ignored
    StallE = 1;
    fcyc(1, 0, 64'hE0); fcyc(1, 0, 64'hE4); fcyc(1, 0, 64'hE8);
    FlushE = 1;
    fcyc(0, 0, 0);
    FlushE = 0;
    BPWrongE = 1; CallE = 1; PCLinkE = 64'h7F0;
    fcyc(1, 0, 64'hF00);
    BPWrongE = 0; CallE = 0; StallE = 0;
    chk("norepair top", RASPCF, 64'hE8);
    chk("norepair count", 64'(RASCountF), 64'd5);

    // Asynchronous reset between edges during a push sequence
    fcyc(1, 0, 64'h111);
    BPCallF = 1; PCLinkF = 64'h222;
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("async RASPCF", RASPCF, 64'h0);
    chk("async count", 64'(RASCountF), 64'd0);
    chk("async ovf", 64'(RASOverflowF), 64'd0);
    @(negedge clk);
    BPCallF = 0;
    @(negedge clk);
    reset = 1;
    fcyc(1, 0, 64'h333);
    chk("post reset top", RASPCF, 64'h333);
    chk("post reset count", 64'(RASCountF), 64'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
